// File: rtl/fft64_reorder.sv
// Converts a 64-point FFT frame from radix-4 digit-reversed order to natural order through two ping-pong banks.
// First bin leaves one clock after the frame completes; in_ready falls only when both banks hold unread frames.
module fft64_reorder #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic [5:0]           out_idx,
  output logic                 out_last
);

  logic [2*DW-1:0] mem [2][64];
  logic [1:0]      full;
  logic [1:0]      full_set;
  logic [1:0]      full_clr;
  logic            wr_bank;
  logic            rd_bank;
  logic [5:0]      wr_cnt;
  logic [5:0]      rd_cnt;
  logic            in_fire;
  logic            load;
  logic [5:0]      rd_addr;
  logic [2*DW-1:0] rd_dat;

  assign in_ready = !full[wr_bank];
  assign in_fire  = in_valid && in_ready;
  assign load     = full[rd_bank] && (!out_valid || out_ready);

  // Natural bin k lives at the address whose base-4 digits are k's digits reversed.
  assign rd_addr = {rd_cnt[1:0], rd_cnt[3:2], rd_cnt[5:4]};
  assign rd_dat  = mem[rd_bank][rd_addr];

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_bank][wr_cnt] <= {in_r, in_i};
    end
  end

  // A bank can only be set while empty and cleared while full, so both never hit the same bank.
  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (in_fire && wr_cnt == 6'd63) full_set[wr_bank] = 1'b1;
    if (load && rd_cnt == 6'd63)    full_clr[rd_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      full <= (full & ~full_clr) | full_set;
      if (in_fire) begin
        wr_cnt <= wr_cnt + 6'd1;
        if (wr_cnt == 6'd63) wr_bank <= !wr_bank;
      end
      if (load) begin
        out_r     <= rd_dat[2*DW-1:DW];
        out_i     <= rd_dat[DW-1:0];
        out_idx   <= rd_cnt;
        out_last  <= (rd_cnt == 6'd63);
        out_valid <= 1'b1;
        rd_cnt    <= rd_cnt + 6'd1;
        if (rd_cnt == 6'd63) rd_bank <= !rd_bank;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft64_reorder.sv
// Directed bench for fft64_reorder: frame scoreboard built from accepted inputs plus hand-computed bins.
module tb_fft64_reorder;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_r;
  logic signed [15:0] in_i;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_r;
  logic signed [15:0] out_i;
  logic [5:0]         out_idx;
  logic               out_last;

  fft64_reorder #(.DW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [38:0] exp_q[$];
  logic [15:0] fr_r [64];
  logic [15:0] fr_i [64];
  logic [15:0] got_r[64];
  logic [15:0] got_i[64];
  int wr_n, sent, base, cyc;
  int out_cnt, last_cnt, first_out, last_out, in_stall;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reverse the three base-4 digits of k.
  function automatic int digrev(int k);
    int x = k;
    int r = 0;
    for (int d = 0; d < 3; d++) begin
      r = r * 4 + x % 4;
      x = x / 4;
    end
    return r;
  endfunction

  task automatic set_data();
    in_r = 16'(base + sent);
    in_i = 16'(-(base + sent));
  endtask

  task automatic clr_stats(int new_base);
    out_cnt   = 0;
    last_cnt  = 0;
    first_out = -1;
    last_out  = -1;
    in_stall  = 0;
    sent      = 0;
    base      = new_base;
    set_data();
  endtask

  // One clock: account for handshakes seen before the edge, then advance to edge+1.
  task automatic tick();
    logic [38:0] e;
    bit in_fire;
    bit out_fire;
    in_fire  = rst_n && in_valid && in_ready;
    out_fire = rst_n && out_valid && out_ready;
    if (rst_n && in_valid && !in_ready) in_stall++;
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {out_idx, out_last, out_r, out_i}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_dat", {out_idx, out_last, out_r, out_i}, e);
      end
      if (out_last) last_cnt++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      out_cnt++;
      got_r[out_idx] = out_r;
      got_i[out_idx] = out_i;
    end
    if (in_fire) begin
      fr_r[wr_n] = in_r;
      fr_i[wr_n] = in_i;
      wr_n++;
      sent++;
      if (wr_n == 64) begin
        wr_n = 0;
        for (int k = 0; k < 64; k++) begin
          int s;
          s = digrev(k);
          exp_q.push_back({6'(k), (k == 63), fr_r[s], fr_i[s]});
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    set_data();
  endtask

  task automatic drain(int max_cyc);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    wr_n = 0;
  endtask

  initial begin
    int g;
    cyc       = 0;
    wr_n      = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_stats(0);

    // Reset values
    do_reset();
    tick_hold_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", {out_idx, out_last, out_r, out_i}, 0);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);

    // Single frame, in_r = n, in_i = -n
    clr_stats(0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    g = 0;
    while (sent < 64 && g < 200) begin tick(); g++; end
    check("t1_sent", sent, 64);
    check("t1_valid_at_accept", out_valid, 0);
    in_valid = 1'b0;
    tick();
    check("t1_first_valid", {out_valid, out_idx}, {1'b1, 6'd0});
    drain(200);
    check("t1_k0",  got_r[0],  16'd0);
    check("t1_k1",  got_r[1],  16'd16);
    check("t1_k2",  got_r[2],  16'd32);
    check("t1_k4",  got_r[4],  16'd4);
    check("t1_k5",  got_r[5],  16'd20);
    check("t1_k63", got_r[63], 16'd63);
    check("t1_k5_im",  got_i[5],  16'hFFEC);
    check("t1_k63_im", got_i[63], 16'hFFC1);
    check("t1_last_cnt", last_cnt, 1);
    check("t1_out_cnt", out_cnt, 64);

    // Four back-to-back frames at full rate
    clr_stats(1000);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    g = 0;
    while (sent < 256 && g < 400) begin tick(); g++; end
    drain(300);
    check("t2_sent", sent, 256);
    check("t2_in_stall", in_stall, 0);
    check("t2_out_cnt", out_cnt, 256);
    check("t2_out_span", last_out - first_out + 1, 256);
    check("t2_last_cnt", last_cnt, 4);

    // Backpressure: two frames stored, third blocked, bin 0 frozen
    clr_stats(2000);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (140) tick();
    check("t3_sent", sent, 128);
    check("t3_in_ready", in_ready, 0);
    check("t3_frozen", {out_valid, out_idx, out_r}, {1'b1, 6'd0, 16'd2000});
    drain(300);
    check("t3_out_cnt", out_cnt, 128);
    check("t3_last_cnt", last_cnt, 2);

    // Random in_valid / out_ready over 20 frames
    clr_stats(3000);
    g = 0;
    while (sent < 1280 && g < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      g++;
    end
    drain(500);
    check("t4_sent", sent, 1280);
    check("t4_out_cnt", out_cnt, 1280);

    // Reset while frame 1 drains at bin 10 and frame 2 holds 40 samples
    clr_stats(5000);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    g = 0;
    while (sent < 104 && g < 300) begin tick(); g++; end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    out_ready = 1'b0;
    check("t5_at_bin10", {out_valid, out_idx}, {1'b1, 6'd10});
    do_reset();
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    clr_stats(6000);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    g = 0;
    while (sent < 64 && g < 200) begin tick(); g++; end
    drain(200);
    check("t5_out_cnt", out_cnt, 64);
    check("t5_k0", got_r[0], 16'd6000);
    check("t5_k1", got_r[1], 16'd6016);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic tick_hold_reset();
    tick();
  endtask

endmodule
